gray_sweep_ctrl: RTL and testbench



---
 rtl/gray_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_gray_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gray_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gray_sweep_ctrl
//
// Self-test sequencer for a binary-to-Gray converter. A start request walks
// every binary code 0..2^WIDTH-1 onto the converter input. Each code is held
// for DWELL settle cycles, then the converter output is captured. Each captured
// Gray word is checked in two ways:
//   - it must match the golden conversion of the code being driven;
//   - it must differ in exactly one bit from the previous code's Gray word.
// Once the last code has been checked, one extra check confirms that the wrap
// from the last code back to code 0 is also a single-bit change. The block
// then reports pass/fail, the number of failing checks and the first failing
// code.
//
// Parameters
//   WIDTH       converter data width
//   DWELL       settle cycles per code before sampling (must be >= 1)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a sweep; only accepted while idle or done
//   b_out       binary code driven to the converter input
//   g_in        Gray word returned by the converter
//   busy        sweep in progress
//   done        sweep finished; held until the next accepted start
//   pass        valid while done=1; set when no check failed
//   err_count   number of failing checks (at most 2^WIDTH+1)
//   fail_valid  at least one failure recorded
//   fail_code   b_out value of the first failure
// -----------------------------------------------------------------------------
//  state    | meaning
//  ---------+-----------------------------------------------------------------
//  ST_IDLE  | waiting for start after reset
//  ST_APPLY | b_out held for DWELL cycles; g_in captured on the last one
//  ST_CHECK | golden + adjacency check of the captured word, then next code
//  ST_WRAP  | single-bit check between the last and the first Gray word
//  ST_DONE  | results held; start launches a fresh sweep
// -----------------------------------------------------------------------------
module gray_sweep_ctrl #(
    parameter int WIDTH = 4,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] b_out,
    input  logic [WIDTH-1:0] g_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic             fail_valid,
    output logic [WIDTH-1:0] fail_code
);

    // Dwell counter is sized to hold 0..DWELL-1; keep at least one bit so
    // DWELL=1 still elaborates.
    localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [DCW-1:0]   DWELL_LAST = DCW'(DWELL - 1);
    localparam logic [DCW-1:0]   DWELL_ONE  = DCW'(1);
    localparam logic [WIDTH-1:0] CODE_MAX   = '1;
    localparam logic [WIDTH-1:0] CODE_ONE   = WIDTH'(1);
    localparam logic [WIDTH:0]   ERR_ONE    = (WIDTH+1)'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_APPLY = 3'd1,
        ST_CHECK = 3'd2,
        ST_WRAP  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state;
    logic [DCW-1:0]   dwell_cnt;
    logic [WIDTH-1:0] g_cur;
    logic [WIDTH-1:0] g_prev;
    logic [WIDTH-1:0] g_first;

    logic [WIDTH-1:0] gold;
    logic             golden_fail;
    logic             adjacent_fail;
    logic             code_fail;
    logic             wrap_fail;

    // Check results are evaluated combinationally from registered values;
    // they are only acted on in ST_CHECK / ST_WRAP.
    always_comb begin
        gold          = b_out ^ (b_out >> 1);
        golden_fail   = (g_cur != gold);
        // Code 0 has no predecessor inside this sweep (g_prev may still hold a
        // word from an earlier sweep); its adjacency is covered by the wrap check.
        adjacent_fail = (b_out != '0) && ($countones(g_cur ^ g_prev) != 1);
        // One failing code counts once even if both tests fail.
        code_fail     = golden_fail || adjacent_fail;
        wrap_fail     = ($countones(g_prev ^ g_first) != 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dwell_cnt  <= '0;
            g_cur      <= '0;
            g_prev     <= '0;
            g_first    <= '0;
            b_out      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_code  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_APPLY;
                        dwell_cnt  <= '0;
                        b_out      <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_code  <= '0;
                    end
                end

                ST_APPLY: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        g_cur <= g_in;
                        state <= ST_CHECK;
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_ONE;
                    end
                end

                ST_CHECK: begin
                    if (code_fail) begin
                        err_count <= err_count + ERR_ONE;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_code  <= b_out;
                        end
                    end
                    g_prev <= g_cur;
                    if (b_out == '0) begin
                        g_first <= g_cur;
                    end
                    if (b_out != CODE_MAX) begin
                        b_out     <= b_out + CODE_ONE;
                        dwell_cnt <= '0;
                        state     <= ST_APPLY;
                    end else begin
                        state <= ST_WRAP;
                    end
                end

                ST_WRAP: begin
                    if (wrap_fail) begin
                        err_count <= err_count + ERR_ONE;
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_code  <= CODE_MAX;
                        end
                    end
                    // err_count already includes every code check here; only
                    // the wrap result is still pending in this cycle.
                    pass  <= (err_count == '0) && !wrap_fail;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
module tb_gray_sweep_ctrl;

    localparam int W      = 4;
    localparam int DWELL  = 2;
    localparam int N      = 1 << W;
    localparam int P      = DWELL + 1;
    localparam int T_DONE = N * P + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] b_out;
    logic [W-1:0] g_in;
    logic         busy;
    logic         done;
    logic         pass;
    logic [W:0]   err_count;
    logic         fail_valid;
    logic [W-1:0] fail_code;

    // converter under test: response per binary code
    logic [W-1:0] lut [N];

    int total = 0;
    int bad   = 0;

    // model state: cycles since the accepted start edge, and per-sweep failure set
    bit         run_seen = 1'b0;
    int         t        = 0;
    logic [N:0] fv_r     = '0;

    // literal expectations for directed sweeps, checked when done rises
    bit         lit_on   = 1'b0;
    int         lit_err  = 0;
    logic       lit_fv   = 1'b0;
    logic [W-1:0] lit_fc = '0;
    logic       lit_pass = 1'b0;

    gray_sweep_ctrl #(.WIDTH(W), .DWELL(DWELL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .b_out      (b_out),
        .g_in       (g_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_code  (fail_code)
    );

    initial forever #5 clk = ~clk;

    always_comb g_in = lut[b_out];

    // Whole-sweep view: bit i = code i fails, bit N = wrap fails.
    function automatic logic [N:0] fail_vec();
        logic [N:0]   r;
        logic [W-1:0] gold;
        r = '0;
        for (int i = 0; i < N; i++) begin
            gold = W'(i ^ (i >> 1));
            if (lut[i] != gold) r[i] = 1'b1;
            if (i != 0 && $countones(lut[i] ^ lut[i-1]) != 1) r[i] = 1'b1;
        end
        r[N] = ($countones(lut[N-1] ^ lut[0]) != 1);
        return r;
    endfunction

    // model: tracks accepted starts and elapsed cycles
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            run_seen = 1'b0;
            t        = 0;
        end else if (start && (!run_seen || t >= T_DONE)) begin
            run_seen = 1'b1;
            t        = 0;
            fv_r     = fail_vec();
        end else if (run_seen && t < 100000) begin
            t = t + 1;
        end
    end

    // compare process: every negedge, DUT outputs vs model
    initial begin
        int           n;
        int           e_err;
        logic         e_fv;
        logic [W-1:0] e_fc;
        logic [W-1:0] e_b;
        logic         e_busy;
        logic         e_done;
        logic         e_pass;
        forever begin
            @(negedge clk);
            e_err = 0; e_fv = 1'b0; e_fc = '0; e_b = '0;
            e_busy = 1'b0; e_done = 1'b0; e_pass = 1'b0;
            if (rst_n === 1'b1 && run_seen) begin
                n = t / P;
                if (n > N) n = N;
                e_b    = (t / P >= N) ? W'(N - 1) : W'(t / P);
                e_busy = (t < T_DONE);
                e_done = !e_busy;
                for (int i = 0; i < n; i++) begin
                    if (fv_r[i]) begin
                        e_err++;
                        if (!e_fv) begin e_fv = 1'b1; e_fc = W'(i); end
                    end
                end
                if (e_done && fv_r[N]) begin
                    e_err++;
                    if (!e_fv) begin e_fv = 1'b1; e_fc = W'(N - 1); end
                end
                e_pass = e_done && (e_err == 0);
            end
            total++;
            if (b_out !== e_b || busy !== e_busy || done !== e_done || pass !== e_pass ||
                err_count !== (W+1)'(e_err) || fail_valid !== e_fv || fail_code !== e_fc) begin
                bad++;
                $display("FAIL outputs t=%0d: got b=%0d busy=%0b done=%0b pass=%0b err=%0d fv=%0b fc=%0d want b=%0d busy=%0b done=%0b pass=%0b err=%0d fv=%0b fc=%0d",
                         t, b_out, busy, done, pass, err_count, fail_valid, fail_code,
                         e_b, e_busy, e_done, e_pass, e_err, e_fv, e_fc);
            end
            if (rst_n === 1'b1 && run_seen && lit_on && t == T_DONE) begin
                total++;
                if (err_count !== (W+1)'(lit_err) || fail_valid !== lit_fv ||
                    fail_code !== lit_fc || pass !== lit_pass || done !== 1'b1) begin
                    bad++;
                    $display("FAIL literal_result: got err=%0d fv=%0b fc=%0d pass=%0b done=%0b want err=%0d fv=%0b fc=%0d pass=%0b done=1",
                             err_count, fail_valid, fail_code, pass, done, lit_err, lit_fv, lit_fc, lit_pass);
                end
                total++;
                if (e_err != lit_err || e_fc !== lit_fc) begin
                    bad++;
                    $display("FAIL model_pin: model err=%0d fc=%0d want err=%0d fc=%0d",
                             e_err, e_fc, lit_err, lit_fc);
                end
            end
            if (rst_n === 1'b1 && run_seen && lit_on && t == T_DONE - 1) begin
                total++;
                if (done !== 1'b0 || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL done_early: got done=%0b busy=%0b want done=0 busy=1", done, busy);
                end
            end
        end
    end

    task automatic set_lut(input int mode, input int pos, input bit val);
        for (int i = 0; i < N; i++) begin
            lut[i] = W'(i ^ (i >> 1));
            case (mode)
                1: lut[i] = W'(i);
                2: lut[i][pos] = val;
                3: if ($urandom_range(0, 5) == 0) lut[i] = W'($urandom_range(0, N - 1));
                4: lut[i] = W'($urandom_range(0, N - 1));
                default: ;
            endcase
        end
    endtask

    task automatic set_lit(input bit on, input int e, input bit fv, input int fc, input bit ps);
        lit_on = on; lit_err = e; lit_fv = fv; lit_fc = W'(fc); lit_pass = ps;
    endtask

    // Accept a start at edge k, then run through edge k+54 (done at k+49).
    task automatic run_sweep(input bit rand_starts, input bit extra10);
        start = 1'b1;
        @(negedge clk); #2;
        for (int i = 1; i <= 54; i++) begin
            start = 1'b0;
            if (rand_starts && i <= 45) start = ($urandom_range(0, 5) == 0);
            if (extra10 && i == 10) start = 1'b1;
            @(negedge clk); #2;
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_lut(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;

        // ideal converter with a start ignored at k+10
        set_lit(1, 0, 1'b0, 0, 1'b1);
        run_sweep(1'b0, 1'b1);

        // identity converter, restarted from DONE
        set_lut(1, 0, 1'b0);
        set_lit(1, 15, 1'b1, 2, 1'b0);
        run_sweep(1'b0, 1'b0);

        // ideal again from DONE: results cleared
        set_lut(0, 0, 1'b0);
        set_lit(1, 0, 1'b0, 0, 1'b1);
        run_sweep(1'b0, 1'b0);

        // bit 0 stuck low: golden fails on 1,2,5,6,9,10,13,14 and, because
        // pairs of codes collapse to the same word, adjacency fails on 3,7,11,15
        set_lut(2, 0, 1'b0);
        set_lit(1, 12, 1'b1, 1, 1'b0);
        run_sweep(1'b0, 1'b0);

        // reset mid-sweep at k+20
        set_lut(0, 0, 1'b0);
        set_lit(0, 0, 1'b0, 0, 1'b0);
        start = 1'b1;
        repeat (21) @(posedge clk);
        start = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        set_lit(1, 0, 1'b0, 0, 1'b1);
        run_sweep(1'b0, 1'b0);

        // randomized converters with random start noise while busy
        set_lit(0, 0, 1'b0, 0, 1'b0);
        for (int s = 0; s < 24; s++) begin
            set_lut(int'($urandom_range(0, 4)), int'($urandom_range(0, W - 1)), 1'($urandom_range(0, 1)));
            run_sweep(1'b1, 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #2;
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
